// File: rtl/sensor_sample_ctrl.sv
// ============================================================================
// sensor_sample_ctrl
//
// Load controller for a bank of NCH D-type hold registers on robot sensor
// lines. Raw sensor bits are synchronised, sampled once per prescaled tick by
// a single round-robin scan engine, and debounced. A channel's hold register
// receives a one-cycle load strobe (with its data bit) only after the channel
// has shown the same value for STABLE consecutive ticks and that value differs
// from the one last committed to the hold register.
//
// Parameters
//   NCH     number of sensor channels / hold registers (1..16)
//   DIV     clk cycles per sample tick; must be greater than NCH+1 so that a
//           full scan always finishes before the next tick
//   STABLE  consecutive equal samples required before a load (>= 1)
//   INI     power-up committed value of every channel (matches the hold
//           registers' own initial value)
//
// Ports
//   clk      in   1        system clock
//   rst_n    in   1        synchronous reset, active low
//   en       in   1        1 = run prescaler and scans, 0 = idle
//   raw      in   NCH      asynchronous sensor inputs
//   load     out  NCH      one-cycle load strobe, one bit per hold register
//   d_out    out  NCH      data to hold registers, d_out[k] valid with load[k]
//   tick     out  1        one-cycle pulse at each sample instant
//   busy     out  1        high while a scan is in progress
//   ch_idx   out  IW       channel currently being evaluated
// ============================================================================
module sensor_sample_ctrl #(
    parameter int   NCH    = 4,
    parameter int   DIV    = 12000,
    parameter int   STABLE = 3,
    parameter logic INI    = 1'b0,
    localparam int  IW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [NCH-1:0] raw,
    output logic [NCH-1:0] load,
    output logic [NCH-1:0] d_out,
    output logic           tick,
    output logic           busy,
    output logic [IW-1:0]  ch_idx
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int CW = (STABLE > 0) ? $clog2(STABLE + 1) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] LAST_CH   = IW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SCAN
    } state_e;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [NCH-1:0] raw_meta_q;     // first synchroniser stage
    logic [NCH-1:0] raw_s_q;        // synchronised sensor bits
    logic [PW-1:0]  presc_q;
    logic           tick_q;

    state_e         state_q;
    logic [IW-1:0]  ch_idx_q;
    logic           busy_q;
    logic [NCH-1:0] load_q;
    logic [NCH-1:0] d_out_q;
    logic [NCH-1:0] committed_q;    // value currently held by each hold register
    logic [NCH-1:0] cand_q;         // value each channel is currently debouncing
    logic [CW-1:0]  cnt_q [NCH];    // consecutive samples equal to cand_q

    // Per-channel evaluation results for the channel under ch_idx_q
    logic           sel_raw;
    logic           sel_cand;
    logic           sel_commit;
    logic [CW-1:0]  sel_cnt;
    logic           cand_d;
    logic [CW-1:0]  cnt_d;
    logic           fire;

    // The scan engine keys off the same condition that raises tick_q, so the
    // first scan cycle coincides with the visible tick pulse.
    logic           presc_wrap;

    assign presc_wrap = en && (presc_q == PRESC_MAX);

    // ------------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the two
    // synchroniser stages into one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_meta_q <= {NCH{INI}};
            raw_s_q    <= {NCH{INI}};
        end else begin
            raw_meta_q <= raw;
            raw_s_q    <= raw_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler and tick generation
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (!en) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= presc_wrap;
            presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce evaluation of the channel currently addressed by ch_idx_q
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default on entry so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel_raw    = raw_s_q[ch_idx_q];
        sel_cand   = cand_q[ch_idx_q];
        sel_commit = committed_q[ch_idx_q];
        sel_cnt    = cnt_q[ch_idx_q];
        cand_d     = sel_raw;
        cnt_d      = sel_cnt;
        fire       = 1'b0;

        if (sel_raw != sel_cand) begin
            // New value seen: restart the run length on this sample.
            cnt_d = CNT_ONE;
        end else if (sel_cnt != CNT_MAX) begin
            cnt_d = sel_cnt + 1'b1;
        end

        // Load only once the run reaches STABLE and the hold register differs.
        // With STABLE=1 a single differing sample loads at once.
        fire = (cnt_d == CNT_MAX) && (cand_d != sel_commit);
    end

    // ------------------------------------------------------------------------
    // Scan FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        assert (DIV > NCH + 1)
            else $error("sensor_sample_ctrl: DIV (%0d) must exceed NCH+1 (%0d)", DIV, NCH + 1);

        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ch_idx_q    <= '0;
            busy_q      <= 1'b0;
            load_q      <= '0;
            d_out_q     <= '0;
            committed_q <= {NCH{INI}};
            cand_q      <= '0;
            // NOTE: the stability counters are a small register array, not a
            // RAM, and must start from a known run length, so each entry is
            // reset explicitly.
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            // Strobe is a single-cycle pulse; any strobe registered on the
            // previous edge has already been presented and now drops.
            load_q <= '0;

            if (!en) begin
                // Abort any scan; the debounce history restarts on re-enable
                // while the committed image of the hold registers is kept.
                state_q  <= ST_IDLE;
                ch_idx_q <= '0;
                busy_q   <= 1'b0;
                cand_q   <= '0;
                for (int k = 0; k < NCH; k++) begin
                    cnt_q[k] <= '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_WAIT;
                    end

                    ST_WAIT: begin
                        if (presc_wrap) begin
                            state_q  <= ST_SCAN;
                            ch_idx_q <= '0;
                            busy_q   <= 1'b1;
                        end
                    end

                    ST_SCAN: begin
                        cand_q[ch_idx_q] <= cand_d;
                        cnt_q[ch_idx_q]  <= cnt_d;

                        if (fire) begin
                            load_q[ch_idx_q]      <= 1'b1;
                            d_out_q[ch_idx_q]     <= cand_d;
                            committed_q[ch_idx_q] <= cand_d;
                        end

                        if (ch_idx_q == LAST_CH) begin
                            state_q  <= ST_WAIT;
                            ch_idx_q <= '0;
                            busy_q   <= 1'b0;
                        end else begin
                            ch_idx_q <= ch_idx_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q  <= ST_IDLE;
                        ch_idx_q <= '0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign load   = load_q;
    assign d_out  = d_out_q;
    assign tick   = tick_q;
    assign busy   = busy_q;
    assign ch_idx = ch_idx_q;

endmodule

// File: tb/tb_sensor_sample_ctrl.sv
// ============================================================================
// tb_sensor_sample_ctrl
//
// Directed bench for sensor_sample_ctrl with NCH=4, DIV=10, STABLE=3, INI=0.
// Expected values are worked out by hand from the debounce behaviour:
// a tick every 10 cycles, channel k strobed k+1 cycles after the tick on
// which its STABLE-th equal sample is taken.
// ============================================================================
module tb_sensor_sample_ctrl;

    localparam int NCH    = 4;
    localparam int DIV    = 10;
    localparam int STABLE = 3;
    localparam int IW     = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] load;
    logic [NCH-1:0] d_out;
    logic           tick;
    logic           busy;
    logic [IW-1:0]  ch_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    sensor_sample_ctrl #(
        .NCH    (NCH),
        .DIV    (DIV),
        .STABLE (STABLE),
        .INI    (1'b0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .raw    (raw),
        .load   (load),
        .d_out  (d_out),
        .tick   (tick),
        .busy   (busy),
        .ch_idx (ch_idx)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
            end
    endtask

    // Advance one clock and sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4 * DIV && !found; i++) begin
            step();
            if (tick) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    // Step until a load strobe appears, counting ticks on the way and the
    // cycles elapsed since the most recent tick.
    task automatic wait_load(output int nt, output int since, output logic [NCH-1:0] ld);
        logic done;
        nt    = 0;
        since = 0;
        ld    = '0;
        done  = 1'b0;
        for (int i = 0; i < 8 * DIV && !done; i++) begin
            step();
            if (tick) begin
                nt++;
                since = 0;
            end else begin
                since++;
            end
            if (load != '0) begin
                ld   = load;
                done = 1'b1;
            end
        end
    endtask

    initial begin
        int nt;
        int nl;
        int since;
        int last;
        int first;
        int bad;
        logic [NCH-1:0] ld;

        rst_n = 1'b0;
        en    = 1'b0;
        raw   = '0;
        repeat (3) step();

        // Reset state
        check("rst_load",   load,   0);
        check("rst_d_out",  d_out,  0);
        check("rst_tick",   tick,   0);
        check("rst_busy",   busy,   0);
        check("rst_ch_idx", ch_idx, 0);

        // 1. Quiet inputs: 40 ticks, exact period, no loads
        rst_n = 1'b1;
        en    = 1'b1;
        nt = 0; nl = 0; last = -1; first = -1; bad = 0;
        for (int i = 1; i <= 40 * DIV; i++) begin
            step();
            if (load != '0) nl++;
            if (tick) begin
                if (first < 0) first = i;
                if (last >= 0 && (i - last) != DIV) bad++;
                nt++;
                last = i;
            end
        end
        check("t1_ticks",      nt,    40);
        check("t1_first_tick", first, DIV);
        check("t1_period_bad", bad,   0);
        check("t1_loads",      nl,    0);

        // Scan sequencing on one tick
        wait_tick("t1_wait_tick");
        check("t1_busy0", busy,   1);
        check("t1_ch0",   ch_idx, 0);
        for (int i = 1; i < NCH; i++) begin
            step();
            check("t1_ch_seq",   ch_idx, i);
            check("t1_busy_seq", busy,   1);
        end
        step();
        check("t1_busy_end", busy,   0);
        check("t1_ch_end",   ch_idx, 0);

        // 2. raw[2] rises mid-period: strobe 3 cycles after the 3rd tick
        step();
        raw = 4'b0100;
        wait_load(nt, since, ld);
        check("t2_ticks", nt,    3);
        check("t2_since", since, 3);
        check("t2_load",  ld,    4'b0100);
        check("t2_d_out", d_out, 4'b0100);
        step();
        check("t2_load_drop", load,  0);
        check("t2_d_hold",    d_out, 4'b0100);

        // 3. 1.5-tick pulse on raw[1]: filtered out
        wait_tick("t3_wait_tick");
        repeat (5) step();
        raw = 4'b0110;
        repeat (15) step();
        raw = 4'b0100;
        nl = 0;
        repeat (6 * DIV) begin
            step();
            if (load != '0) nl++;
        end
        check("t3_loads", nl,    0);
        check("t3_d_out", d_out, 4'b0100);

        // 4. All channels rise together after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        raw   = 4'b1111;
        wait_load(nt, since, ld);
        check("t4_ticks", nt,    3);
        check("t4_since", since, 1);
        check("t4_load0", ld,    4'b0001);
        step();
        check("t4_load1", load,  4'b0010);
        step();
        check("t4_load2", load,  4'b0100);
        step();
        check("t4_load3", load,  4'b1000);
        step();
        check("t4_load_end", load,  0);
        check("t4_d_out",    d_out, 4'b1111);

        // 5. Disable mid-scan, re-enable: history restarts
        raw = 4'b0000;
        wait_tick("t5_tick1");
        wait_tick("t5_tick2");
        step();
        step();
        check("t5_ch_mid",   ch_idx, 2);
        check("t5_busy_mid", busy,   1);
        en = 1'b0;
        step();
        check("t5_busy_off", busy,   0);
        check("t5_ch_off",   ch_idx, 0);
        check("t5_load_off", load,   0);
        nt = 0;
        repeat (2 * DIV) begin
            step();
            if (tick) nt++;
        end
        check("t5_idle_ticks", nt, 0);
        en = 1'b1;
        wait_load(nt, since, ld);
        check("t5_ticks", nt,    3);
        check("t5_since", since, 1);
        check("t5_load0", ld,    4'b0001);
        repeat (3) step();
        check("t5_load3", load,  4'b1000);
        step();
        check("t5_d_out", d_out, 4'b0000);

        // 6. Reset while a strobe is pending
        raw = 4'b1111;
        wait_tick("t6_tick1");
        wait_tick("t6_tick2");
        wait_tick("t6_tick3");
        rst_n = 1'b0;
        step();
        check("t6_load",   load,   0);
        check("t6_d_out",  d_out,  0);
        check("t6_tick",   tick,   0);
        check("t6_busy",   busy,   0);
        check("t6_ch_idx", ch_idx, 0);
        rst_n = 1'b1;
        wait_load(nt, since, ld);
        check("t6_ticks",    nt,    3);
        check("t6_since",    since, 1);
        check("t6_reload",   ld,    4'b0001);
        check("t6_d_reload", d_out, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
